// File: rtl/audio_pkg.sv
// Shared audio definitions used by the I2S serializer, the frame FIFO and the
// bus write adapter. A frame is one stereo sample pair, left channel on top.
package audio_pkg;

   localparam int SAMPLE_W = 24;
   localparam int FRAME_W  = 2 * SAMPLE_W;

   // Bit positions of the two channels inside a packed frame
   localparam int FRAME_L_HI = 47;
   localparam int FRAME_L_LO = 24;
   localparam int FRAME_R_HI = 23;
   localparam int FRAME_R_LO = 0;

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } frame_t;

   // Builds a packed frame from two channel samples
   function automatic logic [FRAME_W-1:0] makeFrame(input logic [SAMPLE_W-1:0] left,
                                                    input logic [SAMPLE_W-1:0] right);
      return {left, right};
   endfunction

   // Extracts the left channel sample from a packed frame
   function automatic logic [SAMPLE_W-1:0] frameLeft(input logic [FRAME_W-1:0] frame);
      return frame[FRAME_L_HI:FRAME_L_LO];
   endfunction

   // Extracts the right channel sample from a packed frame
   function automatic logic [SAMPLE_W-1:0] frameRight(input logic [FRAME_W-1:0] frame);
      return frame[FRAME_R_HI:FRAME_R_LO];
   endfunction

endpackage

// File: rtl/audio_frame_ram.sv
// Simple dual-port frame storage: one synchronous write port, one
// asynchronous read port, so it maps onto distributed RAM and lets the FIFO
// present its head frame in the same cycle the read pointer moves.
module audio_frame_ram
   import audio_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_wrEn,
   input  logic [AW-1:0]      i_wrAddr,
   input  logic [FRAME_W-1:0] i_wrData,
   input  logic [AW-1:0]      i_rdAddr,
   output logic [FRAME_W-1:0] o_rdData
);

   logic [FRAME_W-1:0] r_mem [DEPTH];

   // Store the offered frame on the clock edge; contents are deliberately not
   // reset because the FIFO pointers alone decide what is valid.
   always_ff @(posedge i_clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   // The read side is purely combinational so the head frame falls through.
   always_comb begin
      o_rdData = r_mem[i_rdAddr];
   end

endmodule

// File: rtl/audio_frame_fifo.sv
// Stereo frame FIFO feeding the I2S serializer. The read side is
// first-word-fall-through so the serializer sees the head frame as soon as it
// is stored. Software watches the fill level, the almost-empty flag and the
// underrun flag/counter to keep the codec fed.
module audio_frame_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int ALMOST_EMPTY = 16,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [FRAME_W-1:0] i_wr_data,
   input  logic               i_wr_valid,
   output logic               o_wr_ready,
   output logic [FRAME_W-1:0] o_rd_data,
   output logic               o_rd_valid,
   input  logic               i_rd_ready,
   input  logic               i_flush,
   output logic [AW:0]        o_level,
   output logic               o_almost_empty,
   output logic               o_underrun,
   input  logic               i_underrun_clr,
   output logic [15:0]        o_underrun_cnt
);

   localparam int          LEVEL_W   = AW + 1;
   localparam logic [AW:0] LEVEL_MAX = LEVEL_W'(DEPTH);
   localparam logic [AW:0] LEVEL_AE  = LEVEL_W'(ALMOST_EMPTY);

   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_level;
   logic          r_underrun;
   logic [15:0]   r_underrunCnt;
   logic          r_prevEvent;

   logic          w_wrReady;
   logic          w_rdValid;
   logic          w_push;
   logic          w_pop;
   logic          w_event;
   logic          w_almostEmpty;

   // Handshake decode: a flush or reset blocks both sides, a full FIFO refuses
   // writes even when a pop happens in the same cycle, and an underrun event
   // is the consumer asking for a frame that is not there.
   always_comb begin
      w_wrReady     = !i_rst && (r_level != LEVEL_MAX) && !i_flush;
      w_rdValid     = !i_rst && (r_level != '0);
      w_push        = i_wr_valid && w_wrReady;
      w_pop         = w_rdValid && i_rd_ready && !i_flush;
      w_event       = !i_rst && i_rd_ready && !w_rdValid;
      w_almostEmpty = i_rst || (r_level <= LEVEL_AE);
   end

   // Pointer and level bookkeeping; pointers wrap naturally at AW bits and a
   // flush drops everything while leaving the underrun history alone.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LEVEL_W'(1);
            2'b01:   r_level <= r_level - LEVEL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Underrun tracking: the sticky flag is set on any event (set beats clear),
   // the counter counts only the first cycle of each run of events and stops
   // at all-ones; only reset clears the counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_underrun    <= 1'b0;
         r_underrunCnt <= '0;
         r_prevEvent   <= 1'b0;
      end else begin
         r_prevEvent <= w_event;
         if (w_event) begin
            r_underrun <= 1'b1;
         end else if (i_underrun_clr) begin
            r_underrun <= 1'b0;
         end
         if (w_event && !r_prevEvent && (r_underrunCnt != 16'hFFFF)) begin
            r_underrunCnt <= r_underrunCnt + 16'd1;
         end
      end
   end

   audio_frame_ram #(
      .DEPTH(DEPTH)
   ) u_ram (
      .i_clk    (i_clk),
      .i_wrEn   (w_push),
      .i_wrAddr (r_wrPtr),
      .i_wrData (i_wr_data),
      .i_rdAddr (r_rdPtr),
      .o_rdData (o_rd_data)
   );

   // Drive the status outputs from the decoded and registered state.
   always_comb begin
      o_wr_ready     = w_wrReady;
      o_rd_valid     = w_rdValid;
      o_level        = r_level;
      o_almost_empty = w_almostEmpty;
      o_underrun     = r_underrun;
      o_underrun_cnt = r_underrunCnt;
   end

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Bench for the audio frame FIFO: a queue-based reference model tracks the
// stored frames and underrun state, a small vector table covers the basic
// handshake, and hand-written sequences cover full, empty, underrun and
// flush corner cases.
module tb_audio_frame_fifo;
   import audio_pkg::*;

   localparam int DEPTH = 64;
   localparam int AE    = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic [FRAME_W-1:0] wrData;
   logic               wrValid;
   logic               wrReady;
   logic [FRAME_W-1:0] rdData;
   logic               rdValid;
   logic               rdReady;
   logic               flush;
   logic [6:0]         level;
   logic               almostEmpty;
   logic               underrun;
   logic               underrunClr;
   logic [15:0]        underrunCnt;

   int errors = 0;
   int checks = 0;

   logic [FRAME_W-1:0] sb[$];
   logic               mUnder;
   logic [15:0]        mCnt;
   logic               mPrev;

   typedef struct {
      logic               wv;
      logic [FRAME_W-1:0] wd;
      logic               rr;
      logic               fl;
      logic               clr;
      int                 expLevel;
      logic               expRv;
   } vec_t;

   vec_t tbl[$];

   audio_frame_fifo #(
      .DEPTH(DEPTH),
      .ALMOST_EMPTY(AE)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_wr_data      (wrData),
      .i_wr_valid     (wrValid),
      .o_wr_ready     (wrReady),
      .o_rd_data      (rdData),
      .o_rd_valid     (rdValid),
      .i_rd_ready     (rdReady),
      .i_flush        (flush),
      .o_level        (level),
      .o_almost_empty (almostEmpty),
      .o_underrun     (underrun),
      .i_underrun_clr (underrunClr),
      .o_underrun_cnt (underrunCnt)
   );

   always #5 clk = ~clk;

   // One comparison: counts it and reports a failure with both values
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compares the registered outputs against the reference model
   task automatic checkOutput();
      int n;
      n = sb.size();
      check("level", 64'(level), 64'(n));
      check("rd_valid", 64'(rdValid), 64'(n != 0));
      check("almost_empty", 64'(almostEmpty), 64'(n <= AE));
      check("underrun", 64'(underrun), 64'(mUnder));
      check("underrun_cnt", 64'(underrunCnt), 64'(mCnt));
      if (n != 0) check("head_data", 64'(rdData), 64'(sb[0]));
   endtask

   // Drives one cycle of inputs, checks the handshake, advances the model
   task automatic applyStimulus(input logic wv, input logic [FRAME_W-1:0] wd,
                                input logic rr, input logic fl, input logic clr);
      logic expWr, expRv, doPush, doPop, ev;
      @(negedge clk);
      wrValid = wv; wrData = wd; rdReady = rr; flush = fl; underrunClr = clr;
      #1;
      expWr  = (sb.size() != DEPTH) && !fl;
      expRv  = (sb.size() != 0);
      check("wr_ready", 64'(wrReady), 64'(expWr));
      check("rd_valid_pre", 64'(rdValid), 64'(expRv));
      doPush = wv && expWr;
      doPop  = rr && expRv && !fl;
      ev     = rr && !expRv;
      if (doPop) check("pop_data", 64'(rdData), 64'(sb[0]));
      @(posedge clk);
      if (fl) begin
         sb.delete();
      end else begin
         if (doPop) void'(sb.pop_front());
         if (doPush) sb.push_back(wd);
      end
      if (ev) mUnder = 1'b1;
      else if (clr) mUnder = 1'b0;
      if (ev && !mPrev && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      mPrev = ev;
      #1;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   // Holds reset for two edges, checks reset values, then releases
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; wrValid = 1'b0; wrData = '0; rdReady = 1'b0; flush = 1'b0; underrunClr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_rd_valid", 64'(rdValid), 64'(0));
      check("rst_wr_ready", 64'(wrReady), 64'(0));
      check("rst_almost_empty", 64'(almostEmpty), 64'(1));
      check("rst_level", 64'(level), 64'(0));
      check("rst_underrun", 64'(underrun), 64'(0));
      check("rst_underrun_cnt", 64'(underrunCnt), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      mUnder = 1'b0; mCnt = '0; mPrev = 1'b0;
   endtask

   initial begin
      logic [FRAME_W-1:0] f;
      rst = 1'b1; wrValid = 1'b0; wrData = '0; rdReady = 1'b0; flush = 1'b0; underrunClr = 1'b0;
      sb.delete(); mUnder = 1'b0; mCnt = '0; mPrev = 1'b0;
      doReset();

      // Reset release and single-frame fall-through, with fixed expectations
      tbl.push_back('{1'b0, 48'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0});
      tbl.push_back('{1'b1, 48'h123456abcdef, 1'b0, 1'b0, 1'b0, 1, 1'b1});
      tbl.push_back('{1'b1, 48'h000001000002, 1'b1, 1'b0, 1'b0, 1, 1'b1});
      tbl.push_back('{1'b0, 48'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0});
      tbl.push_back('{1'b1, 48'h7a1cff001300, 1'b0, 1'b0, 1'b0, 1, 1'b1});
      tbl.push_back('{1'b1, 48'h111111222222, 1'b0, 1'b0, 1'b0, 2, 1'b1});
      tbl.push_back('{1'b0, 48'h0, 1'b1, 1'b0, 1'b0, 1, 1'b1});
      tbl.push_back('{1'b0, 48'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0});
      foreach (tbl[i]) begin
         applyStimulus(tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl, tbl[i].clr);
         check($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].expLevel));
         check($sformatf("tbl%0d_rd_valid", i), 64'(rdValid), 64'(tbl[i].expRv));
      end

      // Underrun: one held request counts once, a single request counts again
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle();
      check("ur_flag", 64'(underrun), 64'(1));
      check("ur_cnt2", 64'(underrunCnt), 64'(2));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("ur_clr_flag", 64'(underrun), 64'(0));
      check("ur_clr_cnt", 64'(underrunCnt), 64'(2));
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("ur_set_wins", 64'(underrun), 64'(1));
      check("ur_cnt3", 64'(underrunCnt), 64'(3));
      idle();

      // Fill to full, refuse a 65th write, drain in order across the wrap
      doReset();
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, makeFrame(24'(i), 24'(i + 8'h80)), 1'b0, 1'b0, 1'b0);
      check("full_level", 64'(level), 64'(64));
      applyStimulus(1'b1, 48'hdeadbeef0000, 1'b0, 1'b0, 1'b0);
      check("full_refused", 64'(level), 64'(64));
      for (int i = 0; i < DEPTH; i++) begin
         f = makeFrame(24'(i), 24'(i + 8'h80));
         check("drain_order", 64'(rdData), 64'(f));
         applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      check("drained_level", 64'(level), 64'(0));
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, makeFrame(24'(100 + i), 24'hA5A5A5), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         f = makeFrame(24'(100 + i), 24'hA5A5A5);
         check("wrap_order", 64'(rdData), 64'(f));
         applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end

      // Full FIFO with simultaneous push and pop: pop wins, push next cycle
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, makeFrame(24'($urandom), 24'($urandom)), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 48'hcafe00beef00, 1'b1, 1'b0, 1'b0);
      check("full_pushpop_level", 64'(level), 64'(63));
      applyStimulus(1'b1, 48'hcafe00beef00, 1'b0, 1'b0, 1'b0);
      check("full_retry_level", 64'(level), 64'(64));

      // Reset mid-transfer loses everything
      doReset();
      idle();
      check("midrst_level", 64'(level), 64'(0));

      // Flush with a coincident write, underrun history preserved
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, makeFrame(24'(i), 24'(i)), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 48'h555555aaaaaa, 1'b1, 1'b1, 1'b0);
      check("flush_level", 64'(level), 64'(0));
      check("flush_rd_valid", 64'(rdValid), 64'(0));
      check("flush_keeps_ur", 64'(underrun), 64'(1));
      check("flush_keeps_cnt", 64'(underrunCnt), 64'(1));

      // Stream six frames through as the serializer would pull them
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 48'hffffffffffff, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 48'h000000000000, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 48'h7a1cff001300, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 48'h8000007fffff, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 48'h123456abcdef, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 48'h0000017ffffe, 1'b1, 1'b0, 1'b0);
      check("stream_tail", 64'(rdData), 64'(48'h0000017ffffe));
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle();
      check("stream_no_ur", 64'(underrun), 64'(0));
      check("stream_cnt", 64'(underrunCnt), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_frame_fifo.md
Name: audio_frame_fifo

Overview:
- Synchronous FIFO of stereo audio frames that sits directly upstream of i2s_master and drives its fifo_data/fifo_valid/fifo_ready port.
- Producer side is the CPU/DMA write path. Consumer side is the I2S serializer, which pulls one 48-bit frame per LRCLK period.
- Provides fill level, almost-empty indication and underrun detection so software can keep the codec fed.

Parameters:
- DEPTH, 64, number of frame entries; power of two, >= 4.
- ALMOST_EMPTY, 16, almost_empty asserts when level <= this value.
- AW, $clog2(DEPTH), localparam pointer width; not overridable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_data  in  48  frame {left[23:0], right[23:0]}, left in bits 47:24.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  FIFO accepts; write occurs when wr_valid && wr_ready.
- rd_data  out  48  head frame to i2s_master fifo_data.
- rd_valid  out  1  head frame present; connects to fifo_valid.
- rd_ready  in  1  consumer pop; from i2s_master fifo_ready.
- flush  in  1  synchronous discard of all contents.
- level  out  AW+1  number of stored frames, 0..DEPTH.
- almost_empty  out  1  level <= ALMOST_EMPTY.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  clears underrun.
- underrun_cnt  out  16  saturating count of underrun events.

Behaviour:
- Reset, and every cycle rst is high:
  - Pointers and level are 0; rd_valid=0, wr_ready=0, almost_empty=1.
  - underrun=0, underrun_cnt=0.
  - rd_data is don't-care. Memory contents are not cleared.
- After rst: wr_ready = (level != DEPTH) && !flush.
- Write-to-read latency:
  - The read port is first-word-fall-through: rd_valid = (level != 0), rd_data = mem[rd_ptr] combinationally.
  - A frame written at edge N is visible on rd_data/rd_valid after edge N, i.e. in cycle N+1.
- Pop occurs on a rising edge when rd_valid && rd_ready; rd_ptr increments and wraps modulo DEPTH.
- Push writes mem[wr_ptr]; wr_ptr increments and wraps modulo DEPTH.
- Level update:
  - +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
  - Never exceeds DEPTH and never goes below 0.
- Full (level==DEPTH): wr_ready=0, so a push is refused even if a pop happens in the same cycle. The pop still completes and wr_ready rises the next cycle.
- Empty (level==0): rd_valid=0, so no pop. A simultaneous push is accepted, giving level=1 next cycle.
- Underrun event: a cycle where rd_ready=1 and rd_valid=0.
  - The event sets underrun.
  - underrun_cnt increments once per rising edge of the event condition (held rd_ready counts once) and saturates at 16'hFFFF.
- underrun_clr clears underrun only; underrun_cnt is cleared only by rst. If an underrun event and underrun_clr occur in the same cycle, set wins.
- flush:
  - Pointers and level go to 0 at the next edge.
  - Any push or pop in that cycle is ignored (wr_ready=0 during flush).
  - underrun state is preserved.
- rst mid-transfer: all contents are lost and the reset values above apply. i2s_master is reset from the same rst, so no partial frame is tracked here.
- Registers/state:
  - Pointers wr_ptr and rd_ptr, AW bits each.
  - level register.
  - underrun_cnt, plus 1-bit previous-event register for edge detection.
  - underrun flag.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W=24, FRAME_W=48.
  - Field slices FRAME_L = 47:24, FRAME_R = 23:0.
  - Used by i2s_master, this block, and the bus write adapter.
- One sub-module: audio_frame_ram, a DEPTH x 48 simple dual-port RAM with synchronous write and asynchronous read (distributed RAM).
- Pointer, level and underrun logic live in audio_frame_fifo.

Test Plan:
1. Reset release, no writes -> rd_valid=0, level=0, almost_empty=1, wr_ready=1 from the first cycle after rst deasserts.
2. Write 24'h123456/24'habcdef at edge N -> cycle N+1 shows rd_valid=1 and rd_data=48'h123456abcdef. Pop with rd_ready=1 -> level returns to 0 and rd_valid=0.
3. Write 64 frames with values 0..63 -> wr_ready=0 at level=64 and a 65th write is refused. Pop all 64 -> read order 0..63 exactly, including pointer wrap. Then 10 more writes read back correctly.
4. At level=64, assert wr_valid and rd_ready together -> pop accepted, push refused, level=63. Next cycle the push is accepted, level=64.
5. Empty FIFO, rd_ready held high 5 cycles then low, then high 1 cycle -> underrun=1, underrun_cnt=2. underrun_clr pulse -> underrun=0, cnt stays 2. Clear coinciding with a new event -> underrun stays 1.
6. Load 20 frames then pulse flush together with wr_valid -> next cycle level=0, rd_valid=0, flushed-cycle write discarded. Connect to i2s_master and stream 6 frames (e.g. FFFFFF/FFFFFF, 000000/000000, 7a1cff/001300) -> serialized samples match bit-exact with no underrun.
